// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding, IorD select
// values and the wait-counter width/load helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   localparam logic SEL_INSTR = 1'b0;
   localparam logic SEL_DATA  = 1'b1;

   localparam int unsigned CNT_W = 4;

   // Wait-state load value; anything above the counter range saturates.
   function automatic logic [CNT_W-1:0] wait_load(input int unsigned w);
      if (w > 15) begin
         return 4'd15;
      end
      return CNT_W'(w);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   // data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   // memory side
   logic              IorD;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, IorD, mem_en, mem_we, mem_addr,
             mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, IorD, mem_en, mem_we, mem_addr,
             mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter_addr_sel_mux.sv
// addr_sel_mux: 2:1 address mux steered by IorD (0 = fetch, 1 = data).
module addr_sel_mux
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             sel_i,
   input  logic [WIDTH-1:0] instr_addr_i,
   input  logic [WIDTH-1:0] data_addr_i,
   output logic [WIDTH-1:0] addr_o
);

   // Pick the address of whichever requester currently owns the memory.
   always_comb begin
      addr_o = (sel_i == SEL_DATA) ? data_addr_i : instr_addr_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch and a
// data requester. IDLE arbitrates, ACCESS holds the memory for WAIT_CYCLES+1
// cycles, DONE pulses the matching ack.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// contention; default build uses fixed priority (data over fetch).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] WaitLoad = wait_load(WAIT_CYCLES);

   arb_state_e        state_q;
   logic              iord_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic              if_ack_q;
   logic              d_ack_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              any_req;
   logic              grant_data;
   logic [ADDR_W-1:0] mem_addr;

   assign any_req = bus.if_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
   // 1 = data was granted last; reset value makes fetch win the first contention.
   logic last_data_q;

   // Under contention the requester not served last wins.
   always_comb begin
      if (bus.if_req && bus.d_req) begin
         grant_data = ~last_data_q;
      end else begin
         grant_data = bus.d_req;
      end
   end

   // Remember who got the memory at every grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_data_q <= 1'b1;
      end else if (state_q == IDLE && any_req) begin
         last_data_q <= grant_data;
      end
   end
`else
   // Fixed priority: a data request always beats a fetch.
   always_comb begin
      grant_data = bus.d_req;
   end
`endif

   // Arbitration FSM with registered memory strobes, acks and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         iord_q     <= SEL_INSTR;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         cnt_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  iord_q   <= grant_data;
                  cnt_q    <= WaitLoad;
                  mem_en_q <= 1'b1;
                  mem_we_q <= grant_data & bus.d_we;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (iord_q == SEL_DATA) begin
                     // Stores keep the previous load data.
                     if (!mem_we_q) begin
                        d_rdata_q <= bus.mem_rdata;
                     end
                     d_ack_q <= 1'b1;
                  end else begin
                     if_rdata_q <= bus.mem_rdata;
                     if_ack_q   <= 1'b1;
                  end
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               // Requests seen here wait for the next IDLE.
               if_ack_q <= 1'b0;
               d_ack_q  <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   addr_sel_mux #(
      .WIDTH (ADDR_W)
   ) u_addr_sel_mux (
      .sel_i        (iord_q),
      .instr_addr_i (bus.if_addr),
      .data_addr_i  (bus.d_addr),
      .addr_o       (mem_addr)
   );

   // Drive the bus from registered state.
   always_comb begin
      bus.IorD      = iord_q;
      bus.mem_en    = mem_en_q;
      bus.mem_we    = mem_we_q;
      bus.mem_addr  = mem_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.if_ack    = if_ack_q;
      bus.d_ack     = d_ack_q;
      bus.if_rdata  = if_rdata_q;
      bus.d_rdata   = d_rdata_q;
      bus.busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of lone transactions, contention, reset
// during ACCESS and a zero-wait-state instance. Acks are checked against a
// scoreboard of expected completions.
module tb_mem_port_arbiter;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Memory model: fixed word at 0x100, address-derived pattern elsewhere.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h100) return 32'h8C01_0004;
      return {~a[15:0], a[15:0]};
   endfunction

   assign bus_a.mem_rdata = mem_model(bus_a.mem_addr);
   assign bus_b.mem_rdata = mem_model(bus_b.mem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic        is_data;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];

   task automatic sb_push(input logic is_data, input logic [31:0] rdata, input int c);
      exp_t e;
      e.is_data = is_data;
      e.rdata   = rdata;
      e.cyc     = c;
      sb_q.push_back(e);
   endtask

   // Every ack must match the oldest expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus_a.if_ack || bus_a.d_ack)) begin
         chk("ack_exclusive", 64'(bus_a.if_ack & bus_a.d_ack), 64'd0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none (cycle %0d)",
                     bus_a.if_ack, bus_a.d_ack, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("ack_port", 64'(bus_a.d_ack), 64'(e.is_data));
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            chk("ack_rdata", e.is_data ? 64'(bus_a.d_rdata) : 64'(bus_a.if_rdata),
                64'(e.rdata));
         end
      end
   end

   typedef struct {
      logic        is_data;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_we;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  k;
      int  r;
      logic got;
      logic first_data;
      logic acked_d;
      int  nf;
      int  nd;

      // stores leave d_rdata at the last loaded value (0 after reset)
      vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,         1'b0, 32'h8C01_0004};
      vecs[1] = '{1'b1, 1'b1, 32'h200,  32'hDEAD_BEEF, 1'b1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h300,  32'h0,         1'b0, mem_model(32'h300)};
      vecs[3] = '{1'b1, 1'b1, 32'h0,    32'h1,         1'b1, mem_model(32'h300)};
      vecs[4] = '{1'b0, 1'b0, 32'h404,  32'h0,         1'b0, mem_model(32'h404)};
      vecs[5] = '{1'b1, 1'b0, 32'hFFFC, 32'h0,         1'b0, mem_model(32'hFFFC)};

      bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.d_req = 0; bus_a.d_we = 0;
      bus_a.d_addr = 0; bus_a.d_wdata = 0;
      bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.d_req = 0; bus_b.d_we = 0;
      bus_b.d_addr = 0; bus_b.d_wdata = 0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus_a.busy), 0);
      chk("rst_iord", 64'(bus_a.IorD), 0);
      chk("rst_mem_en", 64'(bus_a.mem_en), 0);
      chk("rst_acks", 64'({bus_a.if_ack, bus_a.d_ack}), 0);
      chk("rst_rdata", {bus_a.if_rdata, bus_a.d_rdata}, 0);
      rst = 0;

      // lone transactions on the W=2 instance
      for (int v = 0; v < 6; v++) begin
         @(posedge clk); #1;
         bus_a.if_req  = !vecs[v].is_data;
         bus_a.d_req   = vecs[v].is_data;
         bus_a.d_we    = vecs[v].we;
         bus_a.if_addr = vecs[v].is_data ? 32'hBAD0 : vecs[v].addr;
         bus_a.d_addr  = vecs[v].is_data ? vecs[v].addr : 32'hBAD4;
         bus_a.d_wdata = vecs[v].wdata;
         k = cyc;
         sb_push(vecs[v].is_data, vecs[v].exp_rdata, k + W + 2);
         chk("idle_busy", 64'(bus_a.busy), 0);
         got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus_a.if_ack || bus_a.d_ack) begin
               got = 1;
            end else if (cyc == k) begin
               chk("pre_mem_en", 64'(bus_a.mem_en), 0);
            end else if (cyc > k && cyc <= k + W + 1) begin
               chk("acc_mem_en", 64'(bus_a.mem_en), 1);
               chk("acc_busy", 64'(bus_a.busy), 1);
               chk("acc_iord", 64'(bus_a.IorD), 64'(vecs[v].is_data));
               chk("acc_mem_we", 64'(bus_a.mem_we), 64'(vecs[v].exp_we));
               chk("acc_mem_addr", 64'(bus_a.mem_addr), 64'(vecs[v].addr));
               if (vecs[v].exp_we) chk("acc_wdata", 64'(bus_a.mem_wdata), 64'(vecs[v].wdata));
            end
         end
         if (!got) chk("ack_timeout", 0, 1);
         else chk("done_mem_en", 64'(bus_a.mem_en), 0);
         @(posedge clk); #1;
         bus_a.if_req = 0;
         bus_a.d_req  = 0;
      end

      // reset in the second ACCESS cycle aborts the fetch
      @(posedge clk); #1;
      bus_a.if_req  = 1;
      bus_a.if_addr = 32'h100;
      k = cyc;
      repeat (3) @(negedge clk);
      chk("abort_busy", 64'(bus_a.busy), 1);
      rst = 1;
      #1;
      chk("abort_busy_rst", 64'(bus_a.busy), 0);
      chk("abort_mem_en", 64'(bus_a.mem_en), 0);
      chk("abort_mem_we", 64'(bus_a.mem_we), 0);
      chk("abort_iord", 64'(bus_a.IorD), 0);
      chk("abort_acks", 64'({bus_a.if_ack, bus_a.d_ack}), 0);
      chk("abort_rdata", {bus_a.if_rdata, bus_a.d_rdata}, 0);
      @(posedge clk); #1;
      rst = 0;
      r = cyc;
      sb_push(1'b0, 32'h8C01_0004, r + W + 2);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus_a.if_ack || bus_a.d_ack) got = 1;
      end
      if (!got) chk("regrant_timeout", 0, 1);
      @(posedge clk); #1;
      bus_a.if_req = 0;

      // contention: both held, each requester served twice
`ifdef MEM_ARB_RR_EN
      first_data = 1'b0;
`else
      first_data = 1'b1;
`endif
      @(posedge clk); #1;
      bus_a.if_addr = 32'h500;
      bus_a.d_addr  = 32'h600;
      bus_a.d_we    = 0;
      bus_a.if_req  = 1;
      bus_a.d_req   = 1;
      k = cyc;
      // one DONE->IDLE cycle separates consecutive grants: 5-cycle spacing
      for (int g = 0; g < 4; g++) begin
         logic is_d;
         is_d = (g % 2 == 0) ? first_data : !first_data;
         sb_push(is_d, mem_model(is_d ? 32'h600 : 32'h500), k + W + 2 + 5 * g);
      end
      nf = 0;
      nd = 0;
      for (int g = 0; g < 4; g++) begin
         got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus_a.if_ack || bus_a.d_ack) got = 1;
         end
         if (!got) begin
            chk("cont_timeout", 0, 1);
            break;
         end
         acked_d = bus_a.d_ack;
         @(posedge clk); #1;
         if (acked_d) begin bus_a.d_req = 0; nd++; end
         else begin bus_a.if_req = 0; nf++; end
         @(posedge clk); #1;
         if (acked_d && nd < 2) bus_a.d_req = 1;
         if (!acked_d && nf < 2) bus_a.if_req = 1;
      end
      bus_a.if_req = 0;
      bus_a.d_req  = 0;

      // zero wait states: one ACCESS cycle, ack two cycles after sampling
      @(posedge clk); #1;
      bus_b.d_req  = 1;
      bus_b.d_we   = 0;
      bus_b.d_addr = 32'h700;
      @(negedge clk);
      chk("w0_pre_en", 64'(bus_b.mem_en), 0);
      @(negedge clk);
      chk("w0_acc_en", 64'(bus_b.mem_en), 1);
      chk("w0_acc_addr", 64'(bus_b.mem_addr), 64'h700);
      chk("w0_acc_ack", 64'(bus_b.d_ack), 0);
      @(negedge clk);
      chk("w0_ack", 64'(bus_b.d_ack), 1);
      chk("w0_rdata", 64'(bus_b.d_rdata), 64'(mem_model(32'h700)));
      chk("w0_done_en", 64'(bus_b.mem_en), 0);
      @(posedge clk); #1;
      bus_b.d_req = 0;
      @(negedge clk);
      chk("w0_ack_pulse", 64'(bus_b.d_ack), 0);

      repeat (4) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
